// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: orders MAR load, MDR enables and memory strobes for single read/write requests.
// Optional ACCESS timeout (ERR state, MAC_error) is built only when MAC_TIMEOUT_EN is defined.
module mem_access_ctrl
`ifdef MAC_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 8
)
`endif
(
    input  logic MAC_clock,
    input  logic MAC_reset,
    input  logic MAC_req,
    input  logic MAC_write,
    input  logic MAC_mem_ready,
    output logic MAC_busy,
    output logic MAC_done,
    output logic MAC_error,
    output logic MAC_mar_load,
    output logic MAC_mdr_bus_in_en,
    output logic MAC_mdr_mem_latch,
    output logic MAC_mdr_bus_out_en,
    output logic MAC_mem_rd,
    output logic MAC_mem_wr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ACCESS,
        ST_DRIVE,
        ST_FINISH
`ifdef MAC_TIMEOUT_EN
        , ST_ERR
`endif
    } state_t;

    state_t state;
    state_t state_next;
    logic   op_write;

    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block, not in the sensitivity list.
    always_ff @(posedge MAC_clock) begin
        if (MAC_reset) begin
            state    <= ST_IDLE;
            op_write <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && MAC_req)
                op_write <= MAC_write;
        end
    end

`ifdef MAC_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Counts not-ready ACCESS cycles already seen; zero on every ACCESS entry.
    logic [7:0] wait_cnt;

    always_ff @(posedge MAC_clock) begin
        if (MAC_reset || state != ST_ACCESS)
            wait_cnt <= '0;
        else if (!MAC_mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
    end
`endif

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (MAC_req) state_next = ST_ADDR;
            ST_ADDR:   state_next = op_write ? ST_DATA : ST_ACCESS;
            ST_DATA:   state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (MAC_mem_ready)
                    state_next = op_write ? ST_FINISH : ST_DRIVE;
`ifdef MAC_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST)
                    state_next = ST_ERR;
`endif
            end
            ST_DRIVE:  state_next = ST_IDLE;
            ST_FINISH: state_next = ST_IDLE;
`ifdef MAC_TIMEOUT_EN
            ST_ERR:    state_next = ST_IDLE;
`endif
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        MAC_busy           = (state != ST_IDLE);
        MAC_done           = 1'b0;
        MAC_error          = 1'b0;
        MAC_mar_load       = 1'b0;
        MAC_mdr_bus_in_en  = 1'b0;
        MAC_mdr_mem_latch  = 1'b0;
        MAC_mdr_bus_out_en = 1'b0;
        MAC_mem_rd         = 1'b0;
        MAC_mem_wr         = 1'b0;
        case (state)
            ST_ADDR:   MAC_mar_load = 1'b1;
            ST_DATA:   MAC_mdr_bus_in_en = 1'b1;
            ST_ACCESS: begin
                MAC_mem_rd = !op_write;
                MAC_mem_wr = op_write;
                // The only Mealy output: MDR grabs read data the cycle memory presents it.
                MAC_mdr_mem_latch = !op_write && MAC_mem_ready;
            end
            ST_DRIVE: begin
                MAC_mdr_bus_out_en = 1'b1;
                MAC_done           = 1'b1;
            end
            ST_FINISH: MAC_done = 1'b1;
`ifdef MAC_TIMEOUT_EN
            ST_ERR: begin
                MAC_done  = 1'b1;
                MAC_error = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, multi-cycle corner sequences,
// and random traffic checked against a transaction-level lookahead model.
module tb_mem_access_ctrl;

    logic MAC_clock = 1'b0;
    logic MAC_reset, MAC_req, MAC_write, MAC_mem_ready;
    logic MAC_busy, MAC_done, MAC_error, MAC_mar_load, MAC_mdr_bus_in_en;
    logic MAC_mdr_mem_latch, MAC_mdr_bus_out_en, MAC_mem_rd, MAC_mem_wr;

    always #5 MAC_clock = ~MAC_clock;

    mem_access_ctrl dut (
        .MAC_clock          (MAC_clock),
        .MAC_reset          (MAC_reset),
        .MAC_req            (MAC_req),
        .MAC_write          (MAC_write),
        .MAC_mem_ready      (MAC_mem_ready),
        .MAC_busy           (MAC_busy),
        .MAC_done           (MAC_done),
        .MAC_error          (MAC_error),
        .MAC_mar_load       (MAC_mar_load),
        .MAC_mdr_bus_in_en  (MAC_mdr_bus_in_en),
        .MAC_mdr_mem_latch  (MAC_mdr_mem_latch),
        .MAC_mdr_bus_out_en (MAC_mdr_bus_out_en),
        .MAC_mem_rd         (MAC_mem_rd),
        .MAC_mem_wr         (MAC_mem_wr)
    );

    // Output vector bit order: busy done error mar bus_in latch bus_out rd wr
    localparam logic [8:0] B  = 9'b1_0000_0000;
    localparam logic [8:0] D  = 9'b0_1000_0000;
    localparam logic [8:0] E  = 9'b0_0100_0000;
    localparam logic [8:0] M  = 9'b0_0010_0000;
    localparam logic [8:0] BI = 9'b0_0001_0000;
    localparam logic [8:0] L  = 9'b0_0000_1000;
    localparam logic [8:0] BO = 9'b0_0000_0100;
    localparam logic [8:0] R  = 9'b0_0000_0010;
    localparam logic [8:0] W  = 9'b0_0000_0001;

`ifdef MAC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TIMEOUT = 8;
    localparam int N = 600;

    logic [8:0] outs;
    assign outs = {MAC_busy, MAC_done, MAC_error, MAC_mar_load, MAC_mdr_bus_in_en,
                   MAC_mdr_mem_latch, MAC_mdr_bus_out_en, MAC_mem_rd, MAC_mem_wr};

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       rst;
        logic       req;
        logic       wr;
        logic       rdy;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];

    logic       rq[N];
    logic       rw[N];
    logic       rr[N];
    logic [8:0] rexp[N];

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (busy done err mar bin latch bout rd wr)", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, compare at the falling edge.
    task automatic run_cycle(input logic rst, input logic req, input logic wr, input logic rdy,
                             input logic [8:0] exp, input string name);
        MAC_reset     = rst;
        MAC_req       = req;
        MAC_write     = wr;
        MAC_mem_ready = rdy;
        @(negedge MAC_clock);
        check(name, outs, exp);
        @(posedge MAC_clock);
        #1;
    endtask

    task automatic put(input int k, input logic [8:0] v);
        if (k < N) rexp[k] = v;
    endtask

    // Request accepted in IDLE cycle c: address next cycle, data phase for writes, then
    // the strobe holds until the first ready cycle (or the timeout), then one completion cycle.
    task automatic build_model();
        int c;
        int a;
        int t;
        bit is_wr;
        bit timed_out;
        logic [8:0] strobe;
        for (int i = 0; i < N; i++) rexp[i] = '0;
        c = 0;
        while (c < N) begin
            if (!rq[c]) begin
                c++;
            end else begin
                is_wr     = rw[c];
                strobe    = is_wr ? (B | W) : (B | R);
                a         = c + (is_wr ? 3 : 2);
                timed_out = 1'b0;
                put(c + 1, B | M);
                if (is_wr) put(c + 2, B | BI);
                t = a;
                while (t < N && !rr[t]) begin
                    if (TO_EN && (t - a + 1 == TIMEOUT)) begin
                        timed_out = 1'b1;
                        break;
                    end
                    put(t, strobe);
                    t++;
                end
                if (t >= N) begin
                    c = N;
                end else if (timed_out) begin
                    put(t, strobe);
                    put(t + 1, B | D | E);
                    c = t + 2;
                end else begin
                    put(t, is_wr ? strobe : (strobe | L));
                    put(t + 1, is_wr ? (B | D) : (B | BO | D));
                    c = t + 2;
                end
            end
        end
    endtask

    initial begin
        MAC_reset     = 1'b1;
        MAC_req       = 1'b0;
        MAC_write     = 1'b0;
        MAC_mem_ready = 1'b0;
        @(posedge MAC_clock);
        #1;

        // rst, req, wr, rdy, expected outputs
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 9'h000});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 9'h000});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 9'h000});
        // read, zero wait; ready high outside ACCESS must be ignored
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 9'h000});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, B | M});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, B | R | L});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, B | BO | D});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 9'h000});
        // write, three wait cycles; write flag dropped after capture
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 9'h000});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, B | M});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, B | BI});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, B | W});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, B | W});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, B | W});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, B | W});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, B | D});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 9'h000});
        // back-to-back reads with req held; busy-time req/write pulses ignored
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 9'h000});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, B | M});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, B | R | L});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, B | BO | D});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 9'h000});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, B | M});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, B | R | L});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, B | BO | D});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 9'h000});

        for (int i = 0; i < tbl.size(); i++)
            run_cycle(tbl[i].rst, tbl[i].req, tbl[i].wr, tbl[i].rdy, tbl[i].exp,
                      $sformatf("tbl[%0d]", i));

        // Reset for two cycles in the middle of a write ACCESS, then a normal read
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 9'h000, "rst_idle");
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, B | M,  "rst_addr");
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, B | BI, "rst_data");
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, B | W,  "rst_access");
        run_cycle(1'b1, 1'b0, 1'b1, 1'b0, B | W,  "rst_cycle1");
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 9'h000, "rst_cycle2");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 9'h000, "rst_after1");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, "rst_after2");
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 9'h000, "post_rst_idle");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, B | M,  "post_rst_addr");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, B | R,  "post_rst_wait");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, B | R | L, "post_rst_access");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, B | BO | D, "post_rst_drive");
        run_cycle(1'b0, 1'b0, 1'b0, 0, 9'h000, "post_rst_back_idle");

`ifdef MAC_TIMEOUT_EN
        // Ready never arrives: TIMEOUT strobe cycles, then done+error, no latch
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 9'h000, "to_idle");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, B | M,  "to_addr");
        for (int i = 0; i < TIMEOUT; i++)
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, B | R, $sformatf("to_wait[%0d]", i));
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, B | D | E, "to_err");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, "to_back_idle");
        // Ready on the last allowed wait cycle wins over the timeout
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 9'h000, "edge_idle");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, B | M,  "edge_addr");
        for (int i = 0; i < TIMEOUT - 1; i++)
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, B | R, $sformatf("edge_wait[%0d]", i));
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, B | R | L, "edge_ready");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, B | BO | D, "edge_drive");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, "edge_back_idle");
`else
        // Without the timeout, ACCESS waits as long as ready stays low
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 9'h000, "long_idle");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, B | M,  "long_addr");
        for (int i = 0; i < 20; i++)
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, B | R, $sformatf("long_wait[%0d]", i));
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, B | R | L, "long_ready");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, B | BO | D, "long_drive");
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, "long_back_idle");
`endif

        // Random traffic against the lookahead model
        for (int i = 0; i < N; i++) begin
            rq[i] = ($urandom_range(0, 2) == 0);
            rw[i] = 1'($urandom_range(0, 1));
            rr[i] = ($urandom_range(0, 9) < 6);
        end
        build_model();
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 9'h000, "rand_reset");
        for (int i = 0; i < N; i++)
            run_cycle(1'b0, rq[i], rw[i], rr[i], rexp[i], $sformatf("rand[%0d]", i));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the memory data path: accepts single read/write requests from the control unit and drives MAR load, MDR enables and the memory strobes in the correct order, waiting on a memory ready handshake. Sits between the control unit and the MAR/MDR/memory group, so only this block touches the memory strobes and MDR enables.

## Interface
- TIMEOUT_CYCLES, 8: consecutive not-ready cycles in ACCESS before abort (timeout build only); range 1–255.

- MAC_clock  in  1  system clock; all state changes on rising edge.
- MAC_reset  in  1  reset, synchronous, active-high.
- MAC_req  in  1  access request; sampled only in IDLE.
- MAC_write  in  1  1 = write, 0 = read; sampled with MAC_req.
- MAC_mem_ready  in  1  memory completes current strobe this cycle.
- MAC_busy  out  1  high in every state except IDLE.
- MAC_done  out  1  one-cycle completion pulse.
- MAC_error  out  1  one-cycle timeout pulse, coincident with MAC_done.
- MAC_mar_load  out  1  MAR captures address from bus.
- MAC_mdr_bus_in_en  out  1  MDR captures write data from bus.
- MAC_mdr_mem_latch  out  1  MDR captures data from memory.
- MAC_mdr_bus_out_en  out  1  MDR drives read data onto bus.
- MAC_mem_rd  out  1  memory read strobe.
- MAC_mem_wr  out  1  memory write strobe.

## Operation
- States: IDLE, ADDR, DATA, ACCESS, DRIVE, FINISH, ERR. Registered op flag holds MAC_write captured in IDLE.
- IDLE: MAC_req=1 → ADDR, latch op; else stay.
- ADDR: MAC_mar_load=1. Read → ACCESS; write → DATA.
- DATA: MAC_mdr_bus_in_en=1 → ACCESS.
- ACCESS: MAC_mem_rd=1 (read) or MAC_mem_wr=1 (write). Stay while MAC_mem_ready=0. On MAC_mem_ready=1: read → DRIVE with MAC_mdr_mem_latch=1 combinationally this cycle (only Mealy output); write → FINISH.
- DRIVE: MAC_mdr_bus_out_en=1, MAC_done=1 → IDLE.
- FINISH: MAC_done=1 → IDLE.
- ERR (timeout build only): MAC_done=1, MAC_error=1, no strobe or MDR enable → IDLE.
- All other outputs Moore-decoded from state; at most one MDR enable and one memory strobe high per cycle.
- MAC_req outside IDLE ignored (not queued); MAC_write changes after capture have no effect.

## Timing
- Reset: state IDLE; all outputs 0 on the first edge with MAC_reset=1. Reset mid-access abandons it: strobes drop next edge, no MAC_done.
- Read, zero wait: req sampled edge 0 → ADDR (cycle 1) → ACCESS (2) → DRIVE (3): MAC_done 3 cycles after request edge. Write zero wait: MAC_done in cycle 4.
- Each cycle of MAC_mem_ready=0 in ACCESS adds one cycle.
- MAC_mem_ready ignored outside ACCESS.
- Back-to-back: after DRIVE/FINISH/ERR the block spends at least one cycle in IDLE; held MAC_req starts next access from that IDLE cycle.

## Configuration
- MAC_TIMEOUT_EN defined: 8-bit wait counter cleared on ACCESS entry, incremented per not-ready ACCESS cycle; when it reaches TIMEOUT_CYCLES with MAC_mem_ready still 0 → ERR. MAC_mem_ready=1 on that same cycle wins (normal completion).
- Not defined: no counter, no ERR state, ACCESS waits indefinitely, MAC_error tied 0.

## Test plan
- Reset: assert MAC_reset 2 cycles mid-ACCESS → all outputs 0, MAC_busy 0, no MAC_done, next request works normally.
- Read, MAC_mem_ready tied 1: MAC_req=1, MAC_write=0 → MAC_mar_load cycle 1, MAC_mem_rd + MAC_mdr_mem_latch cycle 2, MAC_mdr_bus_out_en + MAC_done cycle 3.
- Write with 3 wait cycles: → MAC_mar_load cycle 1, MAC_mdr_bus_in_en cycle 2, MAC_mem_wr cycles 3–6, MAC_done cycle 7.
- MAC_req held high across two reads (ready=1) → second MAC_mar_load exactly one IDLE cycle after first MAC_done; MAC_req pulses while busy ignored.
- MAC_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready held 0 → MAC_mem_rd high 8 cycles, then MAC_done=MAC_error=1 one cycle, MAC_mdr_mem_latch never asserted.
- MAC_TIMEOUT_EN, ready rises on 8th wait cycle → normal completion, MAC_error stays 0.
